// File: rtl/sram_mixed_pkg.sv
// rtl/sram_mixed_pkg.sv - default widths, logic threshold and real/logic level conversion
package sram_mixed_pkg;

  localparam int  DEF_DATA_WIDTH = 8;
  localparam int  DEF_ADDR_WIDTH = 4;
  localparam real DEF_VDD        = 1.8;

  function automatic real vth(input real vdd);
    return vdd / 2.0;
  endfunction

  // Exactly-at-threshold resolves to 0 so a half-swing node never reads as a one.
  function automatic logic to_logic(input real v, input real vdd);
    return (v > vth(vdd));
  endfunction

  function automatic real to_real(input logic b, input real vdd);
    return (b === 1'b1) ? vdd : 0.0;
  endfunction

endpackage

// File: rtl/sram_mixed_core.sv
// rtl/sram_mixed_core.sv - digital read-first single-port memory with async clear
module sram_mixed_core
  import sram_mixed_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  assign dout_d = mem_q[addr];

  // The read samples the pre-edge word, so a write returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      if (we) begin
        mem_q[addr] <= din;
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sram_mixed_xcelium.sv
// rtl/sram_mixed_xcelium.sv - real-voltage wrapper: thresholds inputs, detects clk crossings, drives rail-level outputs
module sram_mixed_xcelium
  import sram_mixed_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter real VDD        = DEF_VDD
) (
  input  real clk,
  input  real rst,
  input  real we,
  input  real addr [ADDR_WIDTH],
  input  real din  [DATA_WIDTH],
  output real dout [DATA_WIDTH]
);

  logic                  clk_l;
  logic                  rst_l;
  logic                  we_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] din_l;
  logic [DATA_WIDTH-1:0] dout_l;

  // A rising edge of clk_l is exactly a crossing from <= VTH to > VTH.
  assign clk_l = to_logic(clk, VDD);
  assign rst_l = to_logic(rst, VDD);
  assign we_l  = to_logic(we, VDD);

  always_comb begin
    addr_l = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      addr_l[i] = to_logic(addr[i], VDD);
    end
  end

  always_comb begin
    din_l = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      din_l[i] = to_logic(din[i], VDD);
    end
  end

  sram_mixed_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk (clk_l),
    .rst (rst_l),
    .we  (we_l),
    .addr(addr_l),
    .din (din_l),
    .dout(dout_l)
  );

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      dout[i] = to_real(dout_l[i], VDD);
    end
  end

endmodule

// File: tb/tb_sram_mixed_xcelium.sv
// tb/tb_sram_mixed_xcelium.sv - scoreboard bench for the real-voltage read-first SRAM
module tb_sram_mixed_xcelium;

  localparam int  DW    = 8;
  localparam int  AW    = 4;
  localparam real VDD_V = 1.8;

  real  clk;
  real  rst;
  real  we;
  real  addr [AW];
  real  din  [DW];
  real  dout [DW];

  logic ph     = 1'b0;
  real  clk_hi = 1.8;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_dout;
  logic [DW-1:0] exp_v;
  logic [DW:0]   obs;

  sram_mixed_xcelium #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .VDD       (VDD_V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .addr(addr),
    .din (din),
    .dout(dout)
  );

  initial clk = 0.0;
  always #5 begin
    ph  = ~ph;
    clk = ph ? clk_hi : 0.0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Bit DW flags any output voltage that is neither rail.
  function automatic logic [DW:0] sample_dout();
    logic [DW:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) begin
      if (dout[i] == VDD_V) r[i] = 1'b1;
      else if (dout[i] != 0.0) r[DW] = 1'b1;
    end
    return r;
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input real hi, input real lo);
    we = w ? hi : lo;
    for (int i = 0; i < AW; i++) addr[i] = a[i] ? hi : lo;
    for (int i = 0; i < DW; i++) din[i] = d[i] ? hi : lo;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input real hi, input real lo);
    @(negedge ph);
    drive(w, a, d, hi, lo);
    exp_q.push_back(model[a]);
    if (w) model[a] = d;
    @(posedge ph);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear_model();
    rst = VDD_V;
    drive(1'b0, '0, '0, VDD_V, 0.0);
    #1;
    obs = sample_dout();
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", obs, {(DW+1){1'b0}});
    end
    @(negedge ph);
    rst = 0.0;
    for (int a = 0; a < 2**AW; a++) begin
      issue(1'b0, a[AW-1:0], '0, VDD_V, 0.0);
      exp_v = exp_q.pop_front();
      obs = sample_dout();
      total++;
      if (obs !== {1'b0, exp_v}) begin
        bad++;
        $display("FAIL reset_read a=%0d: got %h want %h", a, obs, {1'b0, exp_v});
      end
    end
  endtask

  task automatic test_write_read();
    issue(1'b1, 4'd3, 8'hAA, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL write_aa: got %h want %h", obs, {1'b0, exp_v});
    end
    issue(1'b0, 4'd3, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, 8'hAA} || exp_v !== 8'hAA) begin
      bad++;
      $display("FAIL read_aa: got %h want %h", obs, {1'b0, 8'hAA});
    end
    total++;
    if (dout[7] != VDD_V || dout[6] != 0.0 || dout[1] != VDD_V || dout[0] != 0.0) begin
      bad++;
      $display("FAIL aa_levels: got b7=%f b6=%f b1=%f b0=%f want 1.8 0.0 1.8 0.0",
               dout[7], dout[6], dout[1], dout[0]);
    end
  endtask

  task automatic test_read_first();
    issue(1'b1, 4'd3, 8'h55, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL read_first_old: got %h want %h", obs, {1'b0, exp_v});
    end
    issue(1'b0, 4'd3, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL read_first_new: got %h want %h", obs, {1'b0, exp_v});
    end
    last_dout = exp_v;
  endtask

  task automatic test_thresholds();
    issue(1'b1, 4'd6, 8'hA5, 1.0, 0.8);
    void'(exp_q.pop_front());
    issue(1'b0, 4'd6, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL thresh_08_10: got %h want %h", obs, {1'b0, exp_v});
    end
    // Data driven exactly at VTH must store zeros.
    @(negedge ph);
    drive(1'b1, 4'd10, 8'h00, VDD_V, 0.0);
    for (int i = 0; i < DW; i++) din[i] = 0.9;
    model[10] = 8'h00;
    @(posedge ph);
    #1;
    issue(1'b0, 4'd10, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL thresh_exact_vth: got %h want %h", obs, {1'b0, exp_v});
    end
    last_dout = exp_v;
    // A 0.9 V clock swing never crosses VTH: no read, no write.
    @(negedge ph);
    clk_hi = 0.9;
    drive(1'b1, 4'd7, 8'hFF, VDD_V, 0.0);
    repeat (3) @(posedge ph);
    #1;
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, last_dout}) begin
      bad++;
      $display("FAIL weak_clk_hold: got %h want %h", obs, {1'b0, last_dout});
    end
    @(negedge ph);
    drive(1'b0, 4'd7, 8'h00, VDD_V, 0.0);
    clk_hi = VDD_V;
    issue(1'b0, 4'd7, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL weak_clk_nowrite: got %h want %h", obs, {1'b0, exp_v});
    end
  endtask

  task automatic test_hold();
    issue(1'b0, 4'd3, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    last_dout = exp_v;
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL hold_read: got %h want %h", obs, {1'b0, exp_v});
    end
    #1;
    drive(1'b0, 4'd12, 8'hF0, VDD_V, 0.0);
    #1;
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, last_dout}) begin
      bad++;
      $display("FAIL hold_addr_chg1: got %h want %h", obs, {1'b0, last_dout});
    end
    #1;
    drive(1'b0, 4'd6, 8'h0F, VDD_V, 0.0);
    #3;
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, last_dout}) begin
      bad++;
      $display("FAIL hold_addr_chg2: got %h want %h", obs, {1'b0, last_dout});
    end
    issue(1'b0, 4'd6, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL hold_next_edge: got %h want %h", obs, {1'b0, exp_v});
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 4'd15, 8'hFF, VDD_V, 0.0);
    void'(exp_q.pop_front());
    issue(1'b0, 4'd15, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL rst_pre_read: got %h want %h", obs, {1'b0, exp_v});
    end
    @(negedge ph);
    drive(1'b1, 4'd15, 8'h11, VDD_V, 0.0);
    #2;
    rst = VDD_V;
    #1;
    obs = sample_dout();
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rst_immediate: got %h want %h", obs, {(DW+1){1'b0}});
    end
    @(posedge ph);
    #1;
    obs = sample_dout();
    total++;
    if (obs !== '0) begin
      bad++;
      $display("FAIL rst_held_edge: got %h want %h", obs, {(DW+1){1'b0}});
    end
    @(negedge ph);
    drive(1'b0, 4'd0, 8'h00, VDD_V, 0.0);
    rst = 0.0;
    clear_model();
    issue(1'b0, 4'd15, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL rst_cleared_15: got %h want %h", obs, {1'b0, exp_v});
    end
    issue(1'b0, 4'd3, 8'h00, VDD_V, 0.0);
    exp_v = exp_q.pop_front();
    obs = sample_dout();
    total++;
    if (obs !== {1'b0, exp_v}) begin
      bad++;
      $display("FAIL rst_cleared_3: got %h want %h", obs, {1'b0, exp_v});
    end
  endtask

  task automatic test_back_to_back();
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 2**AW - 1));
      d = DW'($urandom);
      issue(w, a, d, VDD_V, 0.0);
      exp_v = exp_q.pop_front();
      obs = sample_dout();
      total++;
      if (obs !== {1'b0, exp_v}) begin
        bad++;
        $display("FAIL b2b n=%0d a=%0d we=%0b: got %h want %h", n, a, w, obs, {1'b0, exp_v});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_thresholds();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mixed_xcelium.md
SRAM_MIXED_XCELIUM -- requirements
Module: sram_mixed_xcelium

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; depth = 2**ADDR_WIDTH words.
REQ-003 Parameter VDD, default 1.8, supply voltage (real) used for driven logic-1 levels.
REQ-004 clk  input  1 (wreal)  single clock; real-valued voltage.
REQ-005 rst  input  1 (wreal)  reset; asynchronous, active-high.
REQ-006 we  input  1 (wreal)  write enable; a voltage above VDD/2 selects write.
REQ-007 addr  input  ADDR_WIDTH (wreal array)  word address; one real voltage per bit.
REQ-008 din  input  DATA_WIDTH (wreal array)  write data; one real voltage per bit.
REQ-009 dout  output  DATA_WIDTH (wreal array)  read data; each bit driven to exactly VDD or 0.0.

Function
REQ-010 Every real input bit SHALL be converted to logic with threshold VTH = VDD/2: a voltage strictly greater than VTH is 1; anything else, including exactly VTH, is 0.
REQ-011 A clock edge SHALL be a crossing of clk from at or below VTH to above VTH; no other clk transition SHALL have any effect.
REQ-012 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits held as logic values.
REQ-013 On each clock edge with rst inactive, dout SHALL be loaded with mem[addr] as it was before that edge (read-first), whether or not we is active.
REQ-014 On the same edge, if we is active, mem[addr] SHALL be updated with din after the read of REQ-013.
REQ-015 A write SHALL therefore return the old contents at that address on dout, and the new data on the following read.
REQ-016 Read latency SHALL be one clock edge; dout SHALL hold its value between edges regardless of changes on addr, din or we.
REQ-017 Each dout bit SHALL be driven to VDD for logic 1 and 0.0 for logic 0; no intermediate voltages.
REQ-018 addr, din and we SHALL be sampled at the clock edge only; changes between edges SHALL have no effect.
REQ-019 Every address value SHALL be valid; no out-of-range case exists.

Reset
REQ-020 When rst rises above VTH, dout SHALL go to 0.0 on all bits and all memory words SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-021 While rst is active, clock edges SHALL be ignored: no writes, and dout SHALL stay at 0.0.
REQ-022 A reset arriving mid-operation SHALL discard any write not yet performed at an edge; the first edge after rst is released SHALL behave per REQ-013 and REQ-014.

Structure
REQ-023 A package sram_mixed_pkg SHALL hold VTH as a function of VDD, the default widths, and the real-to-logic and logic-to-real conversion functions.
REQ-024 One sub-module, sram_mixed_core, SHALL hold the purely digital read-first memory (clk, rst, we, addr, din, dout as logic); the top level SHALL contain only the level conversion and clock-edge detection.

Verification
REQ-025 Apply and release rst, then read addresses 0..15 -> dout is 0.0 on every bit at every address.
REQ-026 Write address 3 with data 0xAA, then read address 3 -> dout bits 7,5,3,1 = 1.8 and bits 6,4,2,0 = 0.0 one edge after the read.
REQ-027 With address 3 holding 0xAA, write 0x55 to address 3 -> dout shows 0xAA at that edge; a read of address 3 at the next edge shows 0x55.
REQ-028 Drive inputs at 0.8 V and at 1.0 V with VDD = 1.8 -> inputs are treated as 0 and as 1 respectively; a clk that rises only to 0.9 V produces no edge.
REQ-029 Write 0xFF to address 15, then assert rst between clock edges -> dout goes to 0.0 immediately; after rst is released, a read of address 15 returns 0x00.
REQ-030 Change addr and din between edges with we low -> dout remains unchanged until the next clock edge.
